// File: rtl/mm2s2mm_ctrl_regs_pkg.sv
// Register map, response codes and small helpers shared by the
// MM2S->S2MM copy-engine control register block.
package mm2s2mm_regs_pkg;

    // Byte offsets within the 256-byte register window
    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_SRC    = 8'h10;
    localparam logic [7:0] OFF_DST    = 8'h14;
    localparam logic [7:0] OFF_LEN    = 8'h18;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // STATUS bit positions
    localparam int ST_MM2S_DONE = 0;
    localparam int ST_S2MM_DONE = 1;
    localparam int ST_LEN_ERR   = 2;

    // CTRL bit positions
    localparam int CTRL_START = 0;
    localparam int CTRL_BUSY  = 0;

    // Merge a write into an existing word, one byte lane per strobe bit
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) merged[8*b +: 8] = new_val[8*b +: 8];
        end
        return merged;
    endfunction

    // True for every offset that has a register behind it
    function automatic logic is_mapped(input logic [7:0] off);
        return off inside {OFF_CTRL, OFF_STATUS, OFF_SRC, OFF_DST, OFF_LEN};
    endfunction

endpackage

// File: rtl/mm2s2mm_ctrl_regs_if.sv
// AXI4-Lite register-port bundle; master drives requests, slave responds.
interface mm2s2mm_ctrl_regs_if #(
    parameter int C_ADDR_WIDTH = 32,
    parameter int C_DATA_WIDTH = 32
);
    logic [C_ADDR_WIDTH-1:0]   awaddr;
    logic                      awvalid;
    logic                      awready;
    logic [C_DATA_WIDTH-1:0]   wdata;
    logic [C_DATA_WIDTH/8-1:0] wstrb;
    logic                      wvalid;
    logic                      wready;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;
    logic [C_ADDR_WIDTH-1:0]   araddr;
    logic                      arvalid;
    logic                      arready;
    logic [C_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                rresp;
    logic                      rvalid;
    logic                      rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/mm2s2mm_ctrl_regs.sv
// Control/status register file for the MM2S->S2MM copy engine.
// Accepts AXI4-Lite writes of SRC/DST/LEN/START, launches the engine with
// latched parameters and gathers its two completion pulses into STATUS.
module mm2s2mm_ctrl_regs
    import mm2s2mm_regs_pkg::*;
#(
    parameter int C_ADDR_WIDTH = 32,
    parameter int C_DATA_WIDTH = 32
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    mm2s2mm_ctrl_regs_if.slave   s_axi,
    output logic                 start,
    output logic [31:0]          src_addr,
    output logic [31:0]          dst_addr,
    output logic [31:0]          len,
    input  logic                 mm2s_done,
    input  logic                 s2mm_done,
    output logic                 busy
);

    logic [C_ADDR_WIDTH-1:0] w_awaddr;
    logic [C_ADDR_WIDTH-1:0] w_araddr;
    logic [7:0]              w_wr_off;
    logic [7:0]              w_rd_off;
    logic                    w_wr_accept;
    logic                    w_rd_accept;
    logic                    w_arready;
    logic                    w_start_cmd;
    logic [31:0]             w_rd_data;
    logic                    w_unused;

    logic                    r_bvalid;
    logic [1:0]              r_bresp;
    logic                    r_rvalid;
    logic [1:0]              r_rresp;
    logic [31:0]             r_rdata;
    logic [C_DATA_WIDTH-1:0] r_src;
    logic [C_DATA_WIDTH-1:0] r_dst;
    logic [C_DATA_WIDTH-1:0] r_len;
    logic [2:0]              r_status;
    logic                    r_start;
    logic                    r_busy;
    logic [31:0]             r_src_lat;
    logic [31:0]             r_dst_lat;
    logic [31:0]             r_len_lat;

    assign w_awaddr = s_axi.awaddr;
    assign w_araddr = s_axi.araddr;
    assign w_wr_off = w_awaddr[7:0];
    assign w_rd_off = w_araddr[7:0];
    assign w_unused = ^{w_awaddr[C_ADDR_WIDTH-1:8], w_araddr[C_ADDR_WIDTH-1:8]};

    // Ready signals are gated by reset so the port looks fully idle while held in reset
    assign w_wr_accept = aresetn & s_axi.awvalid & s_axi.wvalid & ~r_bvalid;
    assign w_arready   = aresetn & ~r_rvalid;
    assign w_rd_accept = w_arready & s_axi.arvalid;
    assign w_start_cmd = w_wr_accept && (w_wr_off == OFF_CTRL)
                         && s_axi.wstrb[0] && s_axi.wdata[CTRL_START];

    assign s_axi.awready = w_wr_accept;
    assign s_axi.wready  = w_wr_accept;
    assign s_axi.bvalid  = r_bvalid;
    assign s_axi.bresp   = r_bresp;
    assign s_axi.arready = w_arready;
    assign s_axi.rvalid  = r_rvalid;
    assign s_axi.rresp   = r_rresp;
    assign s_axi.rdata   = r_rdata;

    assign start    = r_start;
    assign busy     = r_busy;
    assign src_addr = r_src_lat;
    assign dst_addr = r_dst_lat;
    assign len      = r_len_lat;

    // Write path: take AW+W together, hold B until bready, update RW registers when idle
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
            r_src    <= '0;
            r_dst    <= '0;
            r_len    <= '0;
        end else if (w_wr_accept) begin
            r_bvalid <= 1'b1;
            r_bresp  <= is_mapped(w_wr_off) ? RESP_OKAY : RESP_SLVERR;
            if (!r_busy) begin
                case (w_wr_off)
                    OFF_SRC: r_src <= apply_wstrb(r_src, s_axi.wdata, s_axi.wstrb);
                    OFF_DST: r_dst <= apply_wstrb(r_dst, s_axi.wdata, s_axi.wstrb);
                    OFF_LEN: r_len <= apply_wstrb(r_len, s_axi.wdata, s_axi.wstrb);
                    default: ;
                endcase
            end
        end else if (s_axi.bready) begin
            r_bvalid <= 1'b0;
        end
    end

    // Read data select; unmapped offsets read as zero
    always_comb begin
        w_rd_data = '0;
        case (w_rd_off)
            OFF_CTRL:   w_rd_data[CTRL_BUSY] = r_busy;
            OFF_STATUS: w_rd_data[2:0] = r_status;
            OFF_SRC:    w_rd_data = r_src;
            OFF_DST:    w_rd_data = r_dst;
            OFF_LEN:    w_rd_data = r_len;
            default:    w_rd_data = '0;
        endcase
    end

    // Read path: register data on AR handshake, hold R until rready
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rvalid <= 1'b0;
            r_rresp  <= RESP_OKAY;
            r_rdata  <= '0;
        end else if (w_rd_accept) begin
            r_rvalid <= 1'b1;
            r_rresp  <= is_mapped(w_rd_off) ? RESP_OKAY : RESP_SLVERR;
            r_rdata  <= w_rd_data;
        end else if (s_axi.rready) begin
            r_rvalid <= 1'b0;
        end
    end

    // Transfer control: launch on START, collect sticky done bits, drop busy once both are in
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_start   <= 1'b0;
            r_busy    <= 1'b0;
            r_status  <= '0;
            r_src_lat <= '0;
            r_dst_lat <= '0;
            r_len_lat <= '0;
        end else begin
            r_start <= 1'b0;
            if (r_busy) begin
                if (r_status[ST_S2MM_DONE] && r_status[ST_MM2S_DONE]) begin
                    r_busy <= 1'b0;
                end else begin
                    if (mm2s_done) r_status[ST_MM2S_DONE] <= 1'b1;
                    if (s2mm_done) r_status[ST_S2MM_DONE] <= 1'b1;
                end
            end else if (w_start_cmd) begin
                if (r_len != '0) begin
                    r_start   <= 1'b1;
                    r_busy    <= 1'b1;
                    r_status  <= '0;
                    r_src_lat <= r_src;
                    r_dst_lat <= r_dst;
                    r_len_lat <= r_len;
                end else begin
                    // Zero length completes immediately with the error flag raised
                    r_status <= 3'b111;
                end
            end
        end
    end

endmodule

// File: tb/tb_mm2s2mm_ctrl_regs.sv
// Self-checking bench for mm2s2mm_ctrl_regs: table of AXI-Lite accesses plus
// hand sequences for start/done, busy-ignore, zero length, split AW/W,
// B back-pressure and asynchronous reset mid-transfer.
module tb_mm2s2mm_ctrl_regs;
    import mm2s2mm_regs_pkg::*;

    localparam int TMO = 50;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start;
    logic [31:0] src_addr, dst_addr, len;
    logic        mm2s_done = 1'b0;
    logic        s2mm_done = 1'b0;
    logic        busy;

    mm2s2mm_ctrl_regs_if #(.C_ADDR_WIDTH(32), .C_DATA_WIDTH(32)) bus ();

    mm2s2mm_ctrl_regs #(.C_ADDR_WIDTH(32), .C_DATA_WIDTH(32)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s_axi     (bus),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .mm2s_done (mm2s_done),
        .s2mm_done (s2mm_done),
        .busy      (busy)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        string       name;
    } vec_t;

    exp_t rd_q[$];
    exp_t wr_q[$];
    vec_t vecs[16];

    int n_cmp = 0;
    int n_bad = 0;
    int start_cnt = 0;
    int s0;
    logic [31:0] cap_src, cap_dst, cap_len;

    // Count start pulses and capture the parameters presented with each
    always @(negedge aclk) begin
        if (aresetn && start) begin
            start_cnt <= start_cnt + 1;
            cap_src   <= src_addr;
            cap_dst   <= dst_addr;
            cap_len   <= len;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, got);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out after %0d cycles", name, TMO);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic take_bresp();
        exp_t e;
        if (wr_q.size() == 0) begin
            timeout("wr_q_empty");
            return;
        end
        e = wr_q.pop_front();
        check({e.name, "_bresp"}, 32'(bus.bresp), 32'(e.resp));
    endtask

    task automatic take_read();
        exp_t e;
        if (rd_q.size() == 0) begin
            timeout("rd_q_empty");
            return;
        end
        e = rd_q.pop_front();
        check({e.name, "_rdata"}, bus.rdata, e.data);
        check({e.name, "_rresp"}, 32'(bus.rresp), 32'(e.resp));
    endtask

    task automatic wait_bresp();
        int cyc;
        cyc = 0;
        while (!bus.bvalid && cyc < TMO) begin
            tick();
            cyc++;
        end
        if (!bus.bvalid) begin
            timeout("bvalid");
            wr_q.delete();
            return;
        end
        take_bresp();
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
    endtask

    task automatic axi_write(input string name, input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] exp_resp);
        exp_t e;
        bit   hs;
        int   cyc;
        e.name = name; e.data = data; e.resp = exp_resp;
        wr_q.push_back(e);
        bus.awaddr  = {24'h0, addr};
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        hs = 1'b0;
        cyc = 0;
        while (!hs && cyc < TMO) begin
            #1;
            hs = bus.awready;
            tick();
            cyc++;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        if (!hs) begin
            timeout({name, "_awready"});
            wr_q.delete();
            return;
        end
        wait_bresp();
    endtask

    task automatic axi_read(input string name, input logic [7:0] addr,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp);
        exp_t e;
        bit   hs;
        int   cyc;
        e.name = name; e.data = exp_data; e.resp = exp_resp;
        rd_q.push_back(e);
        bus.araddr  = {24'h0, addr};
        bus.arvalid = 1'b1;
        hs = 1'b0;
        cyc = 0;
        while (!hs && cyc < TMO) begin
            #1;
            hs = bus.arready;
            tick();
            cyc++;
        end
        bus.arvalid = 1'b0;
        if (!hs) begin
            timeout({name, "_arready"});
            rd_q.delete();
            return;
        end
        cyc = 0;
        while (!bus.rvalid && cyc < TMO) begin
            tick();
            cyc++;
        end
        if (!bus.rvalid) begin
            timeout({name, "_rvalid"});
            rd_q.delete();
            return;
        end
        take_read();
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
    endtask

    task automatic pulse_done(input logic m, input logic s);
        mm2s_done = m;
        s2mm_done = s;
        tick();
        mm2s_done = 1'b0;
        s2mm_done = 1'b0;
    endtask

    // Hard stop in case a wait outside the bounded tasks ever stalls
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Main stimulus
    initial begin
        vecs[0]  = '{1'b0, OFF_SRC,    32'h0,         4'h0, 32'h0,         RESP_OKAY,   "rd_src_rst"};
        vecs[1]  = '{1'b0, OFF_DST,    32'h0,         4'h0, 32'h0,         RESP_OKAY,   "rd_dst_rst"};
        vecs[2]  = '{1'b0, OFF_LEN,    32'h0,         4'h0, 32'h0,         RESP_OKAY,   "rd_len_rst"};
        vecs[3]  = '{1'b0, OFF_STATUS, 32'h0,         4'h0, 32'h0,         RESP_OKAY,   "rd_status_rst"};
        vecs[4]  = '{1'b0, OFF_CTRL,   32'h0,         4'h0, 32'h0,         RESP_OKAY,   "rd_ctrl_rst"};
        vecs[5]  = '{1'b1, OFF_SRC,    32'hC000_0000, 4'hF, 32'h0,         RESP_OKAY,   "wr_src"};
        vecs[6]  = '{1'b1, OFF_DST,    32'hC000_1000, 4'hF, 32'h0,         RESP_OKAY,   "wr_dst"};
        vecs[7]  = '{1'b1, OFF_LEN,    32'h0000_1000, 4'hF, 32'h0,         RESP_OKAY,   "wr_len"};
        vecs[8]  = '{1'b0, OFF_SRC,    32'h0,         4'h0, 32'hC000_0000, RESP_OKAY,   "rd_src"};
        vecs[9]  = '{1'b0, OFF_DST,    32'h0,         4'h0, 32'hC000_1000, RESP_OKAY,   "rd_dst"};
        vecs[10] = '{1'b0, OFF_LEN,    32'h0,         4'h0, 32'h0000_1000, RESP_OKAY,   "rd_len"};
        vecs[11] = '{1'b0, 8'h08,      32'h0,         4'h0, 32'h0,         RESP_SLVERR, "rd_unmapped"};
        vecs[12] = '{1'b1, 8'h08,      32'hDEAD_BEEF, 4'hF, 32'h0,         RESP_SLVERR, "wr_unmapped"};
        vecs[13] = '{1'b1, OFF_STATUS, 32'hFFFF_FFFF, 4'hF, 32'h0,         RESP_OKAY,   "wr_status"};
        vecs[14] = '{1'b0, OFF_STATUS, 32'h0,         4'h0, 32'h0,         RESP_OKAY,   "rd_status_ro"};
        vecs[15] = '{1'b0, 8'h1C,      32'h0,         4'h0, 32'h0,         RESP_SLVERR, "rd_unmapped_1c"};

        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        check("rst_busy",    32'(busy),        32'h0);
        check("rst_start",   32'(start),       32'h0);
        check("rst_bvalid",  32'(bus.bvalid),  32'h0);
        check("rst_rvalid",  32'(bus.rvalid),  32'h0);
        check("rst_arready", 32'(bus.arready), 32'h0);
        check("rst_rdata",   bus.rdata,        32'h0);
        aresetn = 1'b1;
        tick();

        // Table-driven register accesses
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].wr)
                axi_write(vecs[i].name, vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp);
            else
                axi_read(vecs[i].name, vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp);
        end

        // Normal transfer: one start pulse, sequential done pulses
        s0 = start_cnt;
        axi_write("ctrl_start", OFF_CTRL, 32'h1, 4'hF, RESP_OKAY);
        check("start_count", 32'(start_cnt - s0), 32'd1);
        check("start_src",   cap_src, 32'hC000_0000);
        check("start_dst",   cap_dst, 32'hC000_1000);
        check("start_len",   cap_len, 32'h0000_1000);
        check("busy_on",     32'(busy), 32'h1);
        axi_read("status_busy", OFF_STATUS, 32'h0, RESP_OKAY);
        axi_read("ctrl_busy",   OFF_CTRL,   32'h1, RESP_OKAY);
        pulse_done(1'b1, 1'b0);
        axi_read("status_mm2s", OFF_STATUS, 32'h1, RESP_OKAY);
        check("busy_half",   32'(busy), 32'h1);
        pulse_done(1'b0, 1'b1);
        axi_read("status_both", OFF_STATUS, 32'h3, RESP_OKAY);
        tick();
        check("busy_done",   32'(busy), 32'h0);
        check("start_once",  32'(start_cnt - s0), 32'd1);

        // Byte strobes on SRC
        axi_write("src_wstrb", OFF_SRC, 32'hAAAA_BBBB, 4'b0011, RESP_OKAY);
        axi_read("src_merged", OFF_SRC, 32'hC000_BBBB, RESP_OKAY);

        // Writes and START while busy are ignored but answered OKAY
        s0 = start_cnt;
        axi_write("ctrl_start2", OFF_CTRL, 32'h1, 4'hF, RESP_OKAY);
        check("start2_count", 32'(start_cnt - s0), 32'd1);
        axi_write("src_while_busy",  OFF_SRC,  32'h1234_5678, 4'hF, RESP_OKAY);
        axi_write("ctrl_while_busy", OFF_CTRL, 32'h1,         4'hF, RESP_OKAY);
        check("no_restart",      32'(start_cnt - s0), 32'd1);
        check("src_addr_stable", src_addr, 32'hC000_BBBB);
        axi_read("src_unchanged", OFF_SRC, 32'hC000_BBBB, RESP_OKAY);
        pulse_done(1'b1, 1'b1);
        axi_read("status_simul", OFF_STATUS, 32'h3, RESP_OKAY);
        tick();
        check("busy_done2", 32'(busy), 32'h0);

        // Zero length: no pulse, STATUS=7
        axi_write("len_zero", OFF_LEN, 32'h0, 4'hF, RESP_OKAY);
        s0 = start_cnt;
        axi_write("ctrl_len0", OFF_CTRL, 32'h1, 4'hF, RESP_OKAY);
        axi_read("status_len0", OFF_STATUS, 32'h7, RESP_OKAY);
        check("busy_len0",  32'(busy), 32'h0);
        check("start_len0", 32'(start_cnt - s0), 32'd0);

        // AW presented three cycles ahead of W
        begin
            exp_t e;
            e.name = "aw_early"; e.data = 32'h0BAD_F00D; e.resp = RESP_OKAY;
            wr_q.push_back(e);
        end
        bus.awaddr = {24'h0, OFF_SRC}; bus.wdata = 32'h0BAD_F00D; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("aw_early_wait", 32'(bus.awready), 32'h0);
            tick();
        end
        bus.wvalid = 1'b1;
        #1;
        check("aw_early_go", 32'(bus.awready), 32'h1);
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        wait_bresp();
        axi_read("src_aw_early", OFF_SRC, 32'h0BAD_F00D, RESP_OKAY);

        // bready held low: bvalid holds and the next write stalls
        begin
            exp_t e;
            e.name = "bp_first"; e.data = 32'h1111_0000; e.resp = RESP_OKAY;
            wr_q.push_back(e);
            e.name = "bp_second"; e.data = 32'h2222_0000;
            wr_q.push_back(e);
        end
        bus.awaddr = {24'h0, OFF_DST}; bus.wdata = 32'h1111_0000; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        #1;
        check("bp_first_accept", 32'(bus.awready), 32'h1);
        tick();
        bus.wdata = 32'h2222_0000;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_bvalid_hold", 32'(bus.bvalid),  32'h1);
            check("bp_aw_stall",    32'(bus.awready), 32'h0);
            tick();
        end
        take_bresp();
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        #1;
        check("bp_second_accept", 32'(bus.awready), 32'h1);
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        wait_bresp();
        axi_read("dst_after_bp", OFF_DST, 32'h2222_0000, RESP_OKAY);

        // Asynchronous reset during a transfer with responses pending
        axi_write("len_64", OFF_LEN, 32'h40, 4'hF, RESP_OKAY);
        axi_write("ctrl_start3", OFF_CTRL, 32'h1, 4'hF, RESP_OKAY);
        check("busy_before_rst", 32'(busy), 32'h1);
        bus.araddr = {24'h0, OFF_SRC}; bus.arvalid = 1'b1;
        bus.awaddr = {24'h0, 8'h08}; bus.wdata = 32'h0; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        check("simul_bvalid", 32'(bus.bvalid), 32'h1);
        check("simul_rvalid", 32'(bus.rvalid), 32'h1);
        #2;
        aresetn = 1'b0;
        #1;
        check("arst_busy",   32'(busy),       32'h0);
        check("arst_bvalid", 32'(bus.bvalid), 32'h0);
        check("arst_rvalid", 32'(bus.rvalid), 32'h0);
        check("arst_start",  32'(start),      32'h0);
        check("arst_src",    src_addr,        32'h0);
        check("arst_dst",    dst_addr,        32'h0);
        check("arst_len",    len,             32'h0);
        rd_q.delete();
        wr_q.delete();
        tick();
        tick();
        aresetn = 1'b1;
        tick();
        axi_read("status_after_rst", OFF_STATUS, 32'h0, RESP_OKAY);
        axi_read("src_after_rst",    OFF_SRC,    32'h0, RESP_OKAY);
        axi_read("len_after_rst",    OFF_LEN,    32'h0, RESP_OKAY);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mm2s2mm_ctrl_regs.md
Name: mm2s2mm_ctrl_regs

Overview:
AXI4-Lite responder holding the control/status register file for the MM2S→S2MM copy engine. The VIP master (or PS) writes SRC/DST/LEN and START. The block issues a one-cycle start pulse with latched parameters to the engine, then collects the two completion pulses into a pollable STATUS word. It sits between the AXI interconnect's register port (0x4000_0000 window) and the engine's datapath control.

Parameters:
C_ADDR_WIDTH, 32, AXI4-Lite address width; only bits [7:0] decoded
C_DATA_WIDTH, 32, AXI4-Lite data width; fixed at 32, other values unsupported

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
s_axi_awaddr/awvalid/awready  in/in/out  C_ADDR_WIDTH/1/1  write address channel
s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel
s_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response channel
s_axi_araddr/arvalid/arready  in/in/out  C_ADDR_WIDTH/1/1  read address channel
s_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel
start  out  1  one-cycle pulse to engine
src_addr, dst_addr, len  out  32 each  parameters, stable while busy
mm2s_done, s2mm_done  in  1 each  one-cycle completion pulses from engine
busy  out  1  transfer in flight

Behaviour:
- Register map (byte offsets, word aligned): 0x00 CTRL (W: bit0=START; R: bit0=busy). 0x04 STATUS (R only: bit0 mm2s_done, bit1 s2mm_done, bit2 len_err). 0x10 SRC (RW). 0x14 DST (RW). 0x18 LEN (RW, bytes).
- Reset: all ready/valid outputs 0, bresp/rresp=00, rdata=0, start=0, busy=0, all registers and STATUS bits 0.
- Write: awready=wready=1 for exactly one cycle when awvalid&wvalid&!bvalid. Address and data are accepted together. A lone AW or W waits. bvalid rises the cycle after acceptance and holds until bready. No new write is accepted while bvalid=1.
- wstrb is honoured per byte for SRC/DST/LEN. START is taken only if wstrb[0]&wdata[0].
- Read: arready=1 when !rvalid. rvalid and registered rdata appear the cycle after the AR handshake and hold until rready. The read path is independent of the write path; a simultaneous read and write are both served.
- Responses: mapped offsets return OKAY(00). Unmapped offsets return SLVERR(10); reads of unmapped offsets return rdata=0, and writes to them or to STATUS have no effect.
- Writes to SRC/DST/LEN while busy=1 are ignored but still return OKAY.
- START while busy=1: ignored.
- START while idle with LEN!=0: STATUS cleared; start=1 on the next cycle; busy=1 in the same cycle. src_addr, dst_addr and len are the register values at start.
- START while idle with LEN==0: no start pulse. STATUS becomes 0b111 on the next cycle and busy stays 0.
- While busy: mm2s_done sets STATUS[0] and s2mm_done sets STATUS[1] (sticky). Pulses arriving in the same cycle set both bits. busy clears the cycle after both bits are 1, so a polled STATUS reads 3 at completion.
- Done pulses while idle are ignored.
- A read of STATUS in the same cycle a bit sets returns the pre-update value.
- Asynchronous reset mid-transfer: everything returns to reset values immediately, with no start pulse and no pending response.

Decomposition:
- Package mm2s2mm_regs_pkg: offset constants (CTRL 0x00, STATUS 0x04, SRC 0x10, DST 0x14, LEN 0x18), resp constants (RESP_OKAY 2'b00, RESP_SLVERR 2'b10), STATUS bit indices.
- No sub-module is needed: the write path, read path and transfer-control logic are three always blocks in one module.

Test Plan:
- Reset, then read 0x10/0x14/0x18/0x04: all rdata=0, rresp=00; busy=0, start=0.
- Write SRC=0xC000_0000, DST=0xC000_1000, LEN=4096 (0x1000), then CTRL=1: exactly one start pulse with those values; busy=1; STATUS reads 0. Pulse mm2s_done then s2mm_done: STATUS reads 1 then 3; busy=0.
- While busy, write SRC=0x1234_5678 and CTRL=1: bresp=00 for both, src_addr unchanged, no second start. Simultaneous done pulses: STATUS=3 next read.
- LEN=0, CTRL=1: no start pulse, STATUS reads 7, busy=0.
- Write wstrb=4'b0011 data 0xAAAA_BBBB to SRC holding 0xC000_0000: SRC reads 0xC000_BBBB. Read/write 0x08: SLVERR, rdata=0. AW presented 3 cycles before W: single handshake when W arrives. bready held low 5 cycles: bvalid holds and the next write stalls.
- Assert aresetn=0 mid-transfer (busy=1): busy, bvalid, rvalid and all registers return to 0 in the same cycle. After release, STATUS reads 0.
